deser16_word_assembler: RTL and testbench

- Serial-to-parallel front stage. Collects a bit stream into 16-bit words and presents each word on a registered valid/ready output.
- Sits directly upstream of the 16-bit sync-reset pipeline register and the 16-bit 2:1 word mux. Its word_out drives their 16-bit data inputs.
- Double-buffered: shifting continues while a completed word waits for the consumer.

---
 rtl/deser16_word_assembler.sv | 111 +++++++++++
 tb/tb_deser16_word_assembler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/deser16_word_assembler.sv
// Serial-to-parallel 16-bit word assembler, double-buffered valid/ready out.
// Define DESER16_PARITY_EN for a trailing even-parity bit and parity_err.
module deser16_word_assembler #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [4:0]       bit_count,
  output logic             overrun,
  output logic             busy
`ifdef DESER16_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

`ifdef DESER16_PARITY_EN
  localparam logic [4:0] LAST = 5'd16;
`else
  localparam logic [4:0] LAST = 5'd15;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] done_word;
  logic             complete;
  logic             load;

  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg[WIDTH-2:0], sin};
      first   = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      shifted = {sin, shreg[WIDTH-1:1]};
      first   = {sin, {(WIDTH-1){1'b0}}};
    end
`ifdef DESER16_PARITY_EN
    // Last serial bit is parity; data is already complete in shreg.
    done_word = shreg;
`else
    done_word = shifted;
`endif
    complete = sin_valid && !sof
            && (bit_count == LAST);
    load = complete
        && (!word_valid || word_ready);
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_count  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef DESER16_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (sin_valid) begin
        unique case (1'b1)
          sof: begin
            shreg     <= first;
            bit_count <= 5'd1;
            state     <= SHIFT;
          end
          complete: begin
            shreg     <= '0;
            bit_count <= '0;
            state     <= IDLE;
          end
          default: begin
            shreg     <= shifted;
            bit_count <= bit_count + 5'd1;
            state     <= SHIFT;
          end
        endcase
      end
      // Completion into a full buffer drops the word.
      if (load) begin
        word_out   <= done_word;
        word_valid <= 1'b1;
`ifdef DESER16_PARITY_EN
        parity_err <= (^shreg) ^ sin;
`endif
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deser16_word_assembler.sv
// Bench for deser16_word_assembler: vector table, corner sequences,
// and random traffic against a bit-queue reference model.
module tb_deser16_word_assembler;

  localparam bit MSB = 1'b1;
`ifdef DESER16_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sin = 1'b0;
  logic        sin_valid = 1'b0;
  logic        sof = 1'b0;
  logic        word_ready = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic [4:0]  bit_count;
  logic        overrun;
  logic        busy;
`ifdef DESER16_PARITY_EN
  logic        parity_err;
`endif

  deser16_word_assembler #(
    .WIDTH(16),
    .MSB_FIRST(MSB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sin(sin),
    .sin_valid(sin_valid),
    .sof(sof),
    .word_out(word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .bit_count(bit_count),
    .overrun(overrun),
    .busy(busy)
`ifdef DESER16_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // Reference model: bits received so far and the output buffer.
  bit          q[$];
  bit          m_valid = 0;
  logic [15:0] m_word = '0;
  bit          m_ovr = 0;
  bit          m_perr = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          comp;
    bit          pe;
    logic [15:0] w;
    comp = 0;
    w = '0;
    pe = 0;
    if (reset) begin
      q.delete();
      m_valid = 0;
      m_word = '0;
      m_ovr = 0;
      m_perr = 0;
      return;
    end
    if (sin_valid) begin
      if (sof) q.delete();
      q.push_back(sin);
      if (!sof && q.size() == NB) begin
        for (int i = 0; i < 16; i++)
          w = w | (16'(q[i]) << (MSB ? 15 - i : i));
        for (int i = 0; i < NB; i++)
          pe = pe ^ q[i];
        comp = 1;
        q.delete();
      end
    end
    if (comp) begin
      if (!m_valid || word_ready) begin
        m_word = w;
        m_valid = 1;
        m_perr = pe;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && word_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_valid", word_valid, m_valid);
    chk("m_word", word_out, m_word);
    chk("m_count", bit_count, q.size());
    chk("m_ovr", overrun, m_ovr);
    chk("m_busy", busy, q.size() != 0);
`ifdef DESER16_PARITY_EN
    chk("m_perr", parity_err, m_perr);
`endif
  endtask

  task automatic send_word(logic [15:0] w, bit first_sof, bit rdy, bit pbit);
    for (int i = 0; i < NB; i++) begin
      sin_valid = 1;
      sof = first_sof && (i == 0);
      word_ready = rdy;
      if (i < 16) sin = MSB ? w[15-i] : w[i];
      else sin = pbit;
      step();
    end
    sin_valid = 0;
    sof = 0;
  endtask

  typedef struct {
    logic [15:0] w;
    logic [15:0] exp_out;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'hA5C3, 16'hA5C3, 1'b0};
    vecs[1] = '{16'h1234, 16'h1234, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{16'h8001, 16'h8001, 1'b0};

    reset = 1;
    step();
    step();
    chk("rst_out", word_out, 16'h0000);
    chk("rst_valid", word_valid, 0);
    chk("rst_count", bit_count, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 0;

    // Back-to-back words with ready held high.
    for (int k = 0; k < 5; k++) begin
      send_word(vecs[k].w, 0, 1, ^vecs[k].w);
      chk("tbl_valid", word_valid, 1);
      chk("tbl_out", word_out, vecs[k].exp_out);
      chk("tbl_count", bit_count, 0);
      chk("tbl_ovr", overrun, vecs[k].exp_ovr);
    end
    word_ready = 1;
    step();
    chk("tbl_drop", word_valid, 0);

    // Stalled consumer: second completion overruns.
    send_word(16'h00FF, 0, 0, 0);
    chk("ovr_v1", word_valid, 1);
    send_word(16'h0F0F, 0, 0, 0);
    chk("ovr_out", word_out, 16'h00FF);
    chk("ovr_flag", overrun, 1);
    chk("ovr_v2", word_valid, 1);
    word_ready = 1;
    step();
    chk("ovr_drain", word_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // Partial word discarded by sof.
    for (int i = 0; i < 7; i++) begin
      sin_valid = 1;
      sin = 1'($urandom);
      step();
    end
    chk("sof_part", bit_count, 7);
    send_word(16'hBEEF, 1, 1, ^16'hBEEF);
    chk("sof_out", word_out, 16'hBEEF);
    chk("sof_valid", word_valid, 1);

    // Reset mid-word.
    for (int i = 0; i < 10; i++) begin
      sin_valid = 1;
      sin = 1'($urandom);
      step();
    end
    sin_valid = 0;
    reset = 1;
    step();
    chk("mid_count", bit_count, 0);
    chk("mid_valid", word_valid, 0);
    chk("mid_out", word_out, 16'h0000);
    chk("mid_ovr", overrun, 0);
    reset = 0;
    send_word(16'h8001, 0, 1, 0);
    chk("mid_word", word_out, 16'h8001);
    chk("mid_v", word_valid, 1);

`ifdef DESER16_PARITY_EN
    send_word(16'h0001, 0, 1, 1);
    chk("par_ok", parity_err, 0);
    send_word(16'h0001, 0, 1, 0);
    chk("par_bad", parity_err, 1);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      sin_valid = ($urandom_range(0, 3) != 0);
      sof = ($urandom_range(0, 39) == 0);
      sin = 1'($urandom);
      word_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
